// File: rtl/dii_package.sv
// Shared DII debug-ring types: flit bundle, ring steering tag, subnet match.
// Used by the gateway demux/mux and by verification.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic [1:0] {
    SEL_LOCAL = 2'd0,
    SEL_RING  = 2'd1,
    SEL_EXT   = 2'd2
  } ring_sel_t;

  // True when the top `bits` bits of dest equal subnet.
  function automatic logic dii_subnet_match(
    input logic [15:0] dest,
    input logic [15:0] subnet,
    input int unsigned bits
  );
    logic [15:0] field;
    field = dest >> (16 - bits);
    return field == subnet;
  endfunction

endpackage

// File: rtl/ring_router_gateway_demux_slice.sv
// One-entry valid/ready register slice for a flit plus a 2-bit tag.
// Ports: in_flit/in_tag/in_ready upstream; buf_* and out_ready downstream.
module dii_flit_slice
  import dii_package::*;
(
  input  logic        clk,
  input  logic        rst,
  input  dii_flit     in_flit,
  input  logic [1:0]  in_tag,
  output logic        in_ready,
  output logic        buf_valid,
  output logic        buf_last,
  output logic [15:0] buf_data,
  output logic [1:0]  buf_tag,
  input  logic        out_ready
);

  // Pass-through ready: a draining entry can be replaced the same cycle.
  assign in_ready = !buf_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_last  <= 1'b0;
      buf_data  <= '0;
      buf_tag   <= '0;
    end else if (in_flit.valid && in_ready) begin
      buf_valid <= 1'b1;
      buf_last  <= in_flit.last;
      buf_data  <= in_flit.data;
      buf_tag   <= in_tag;
    end else if (out_ready) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_router_gateway_demux.sv
// Gateway ingress demux: steers DII worms to local, ring or external port.
// Ports: clk, rst, id, in_ring/in_ring_ready, out_{local,ring,ext}(+_ready).
module ring_router_gateway_demux
  import dii_package::*;
#(
  parameter int SUBNET_BITS  = 6,
  parameter int LOCAL_SUBNET = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  dii_flit     in_ring,
  output logic        in_ring_ready,
  output dii_flit     out_local,
  input  logic        out_local_ready,
  output dii_flit     out_ring,
  input  logic        out_ring_ready,
  output dii_flit     out_ext,
  input  logic        out_ext_ready
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WORM_LOCAL = 2'd1,
    WORM_RING  = 2'd2,
    WORM_EXT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  ring_sel_t   hdr_sel;
  ring_sel_t   sel;
  logic        accept;
  logic        tgt_ready;
  logic        buf_valid;
  logic        buf_last;
  logic [15:0] buf_data;
  logic [1:0]  buf_tag;

  assign accept = in_ring.valid && in_ring_ready;

  always_comb begin
    hdr_sel = SEL_EXT;
    if (in_ring.data == id)
      hdr_sel = SEL_LOCAL;
    else if (dii_subnet_match(in_ring.data,
                              16'(LOCAL_SUBNET),
                              SUBNET_BITS))
      hdr_sel = SEL_RING;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Only IDLE decodes; inside a worm the target is pinned.
  always_comb begin
    state_nxt = state;
    sel       = hdr_sel;
    unique case (state)
      IDLE: begin
        if (accept && !in_ring.last) begin
          case (hdr_sel)
            SEL_LOCAL: state_nxt = WORM_LOCAL;
            SEL_RING:  state_nxt = WORM_RING;
            default:   state_nxt = WORM_EXT;
          endcase
        end
      end
      WORM_LOCAL: begin
        sel = SEL_LOCAL;
        if (accept && in_ring.last) state_nxt = IDLE;
      end
      WORM_RING: begin
        sel = SEL_RING;
        if (accept && in_ring.last) state_nxt = IDLE;
      end
      WORM_EXT: begin
        sel = SEL_EXT;
        if (accept && in_ring.last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (buf_tag)
      SEL_LOCAL: tgt_ready = out_local_ready;
      SEL_RING:  tgt_ready = out_ring_ready;
      SEL_EXT:   tgt_ready = out_ext_ready;
      default:   tgt_ready = 1'b0;
    endcase
  end

  dii_flit_slice u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_ring),
    .in_tag    (sel),
    .in_ready  (in_ring_ready),
    .buf_valid (buf_valid),
    .buf_last  (buf_last),
    .buf_data  (buf_data),
    .buf_tag   (buf_tag),
    .out_ready (tgt_ready)
  );

  // Data/last fan out to all ports; only valid is gated.
  assign out_local.valid = buf_valid && (buf_tag == SEL_LOCAL);
  assign out_local.last  = buf_last;
  assign out_local.data  = buf_data;
  assign out_ring.valid  = buf_valid && (buf_tag == SEL_RING);
  assign out_ring.last   = buf_last;
  assign out_ring.data   = buf_data;
  assign out_ext.valid   = buf_valid && (buf_tag == SEL_EXT);
  assign out_ext.last    = buf_last;
  assign out_ext.data    = buf_data;

endmodule

// File: tb/tb_ring_router_gateway_demux.sv
// Directed self-checking bench for ring_router_gateway_demux.
// Second instance exercises LOCAL_SUBNET=3 decoding.
module tb_ring_router_gateway_demux;
  import dii_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id;
  dii_flit     in_ring;
  logic        in_ring_ready;
  dii_flit     out_local, out_ring, out_ext;
  logic        out_local_ready, out_ring_ready, out_ext_ready;

  logic [15:0] id3;
  dii_flit     in3;
  logic        in3_ready;
  dii_flit     l3, r3, e3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ring_router_gateway_demux dut (
    .clk             (clk),
    .rst             (rst),
    .id              (id),
    .in_ring         (in_ring),
    .in_ring_ready   (in_ring_ready),
    .out_local       (out_local),
    .out_local_ready (out_local_ready),
    .out_ring        (out_ring),
    .out_ring_ready  (out_ring_ready),
    .out_ext         (out_ext),
    .out_ext_ready   (out_ext_ready)
  );

  ring_router_gateway_demux #(
    .SUBNET_BITS  (6),
    .LOCAL_SUBNET (3)
  ) dut3 (
    .clk             (clk),
    .rst             (rst),
    .id              (id3),
    .in_ring         (in3),
    .in_ring_ready   (in3_ready),
    .out_local       (l3),
    .out_local_ready (1'b1),
    .out_ring        (r3),
    .out_ring_ready  (1'b1),
    .out_ext         (e3),
    .out_ext_ready   (1'b1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // v = {local, ring, ext} valids; data/last checked only when a port is valid.
  task automatic chk_out(input string tag, input logic [2:0] v,
                         input logic [15:0] d, input logic l);
    chk({tag, "_v"},
        {29'd0, out_local.valid, out_ring.valid, out_ext.valid},
        {29'd0, v});
    if (v != 3'b000) begin
      chk({tag, "_d"}, {16'd0, out_local.data}, {16'd0, d});
      chk({tag, "_l"}, {31'd0, out_local.last}, {31'd0, l});
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] v);
    chk(tag, {29'd0, l3.valid, r3.valid, e3.valid}, {29'd0, v});
  endtask

  localparam logic [2:0] VL = 3'b100;
  localparam logic [2:0] VR = 3'b010;
  localparam logic [2:0] VE = 3'b001;
  localparam logic [2:0] VN = 3'b000;

  logic [15:0] w2_d [4] = '{16'h0009, 16'hFFFF, 16'h0005, 16'h1234};
  logic [15:0] b_d  [6] = '{16'h0005, 16'h0009, 16'h0401,
                            16'h0005, 16'h0009, 16'h0401};
  logic [2:0]  b_v  [6] = '{VL, VL, VE, VE, VR, VR};

  initial begin
    rst             = 1'b1;
    id              = 16'h0000;
    in_ring         = '0;
    out_local_ready = 1'b1;
    out_ring_ready  = 1'b1;
    out_ext_ready   = 1'b1;
    id3             = 16'h0000;
    in3             = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    chk_out("rst", VN, 16'h0, 1'b0);
    chk("rst_data", {16'd0, out_ext.data}, 32'd0);
    chk("rst_rdy", {31'd0, in_ring_ready}, 32'd1);

    // Single-flit worm to local.
    id      = 16'h0005;
    in_ring = '{valid: 1'b1, last: 1'b1, data: 16'h0005};
    cyc();
    chk_out("single", VL, 16'h0005, 1'b1);
    in_ring = '0;
    cyc();
    chk_out("single_drain", VN, 16'h0, 1'b0);

    // 4-flit ring worm; payload 0x0005 must not be redirected.
    for (int i = 0; i < 4; i++) begin
      in_ring = '{valid: 1'b1, last: (i == 3), data: w2_d[i]};
      cyc();
      chk_out($sformatf("ringw%0d", i), VR, w2_d[i], i == 3);
    end
    in_ring = '0;
    cyc();
    chk_out("ringw_end", VN, 16'h0, 1'b0);

    // Ext worm with a 3-cycle downstream stall.
    in_ring = '{valid: 1'b1, last: 1'b0, data: 16'h0401};
    cyc();
    chk_out("ext_hdr", VE, 16'h0401, 1'b0);
    out_ext_ready = 1'b0;
    in_ring = '{valid: 1'b1, last: 1'b0, data: 16'hAAAA};
    #1;
    chk("stall_rdy", {31'd0, in_ring_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out($sformatf("stall%0d", i), VE, 16'h0401, 1'b0);
      chk($sformatf("stall_rdy%0d", i), {31'd0, in_ring_ready}, 32'd0);
    end
    out_ext_ready = 1'b1;
    #1;
    chk("unstall_rdy", {31'd0, in_ring_ready}, 32'd1);
    cyc();
    chk_out("ext_p1", VE, 16'hAAAA, 1'b0);
    in_ring = '{valid: 1'b1, last: 1'b1, data: 16'hBBBB};
    cyc();
    chk_out("ext_p2", VE, 16'hBBBB, 1'b1);
    in_ring = '0;
    cyc();
    chk_out("ext_end", VN, 16'h0, 1'b0);

    // Back-to-back worms local, ext, ring with no gaps.
    for (int i = 0; i < 6; i++) begin
      in_ring = '{valid: 1'b1, last: i[0], data: b_d[i]};
      #1;
      chk($sformatf("b2b_rdy%0d", i), {31'd0, in_ring_ready}, 32'd1);
      cyc();
      chk_out($sformatf("b2b%0d", i), b_v[i], b_d[i], i[0]);
    end
    in_ring = '0;
    cyc();
    chk_out("b2b_end", VN, 16'h0, 1'b0);

    // Reset in the middle of a ring worm.
    in_ring = '{valid: 1'b1, last: 1'b0, data: 16'h0009};
    cyc();
    in_ring = '{valid: 1'b1, last: 1'b0, data: 16'h1111};
    cyc();
    chk_out("pre_rst", VR, 16'h1111, 1'b0);
    in_ring = '0;
    rst     = 1'b1;
    cyc();
    rst = 1'b0;
    chk_out("mid_rst", VN, 16'h0, 1'b0);
    chk("mid_rst_rdy", {31'd0, in_ring_ready}, 32'd1);
    in_ring = '{valid: 1'b1, last: 1'b1, data: 16'h0005};
    cyc();
    chk_out("post_rst", VL, 16'h0005, 1'b1);
    in_ring = '0;
    cyc();

    // LOCAL_SUBNET=3 instance.
    in3 = '{valid: 1'b1, last: 1'b1, data: 16'h0C10};
    cyc();
    chk3("sn3_ring", VR);
    id3 = 16'h0C10;
    in3 = '{valid: 1'b1, last: 1'b1, data: 16'h0810};
    cyc();
    chk3("sn3_ext", VE);
    in3 = '{valid: 1'b1, last: 1'b1, data: 16'h0C10};
    cyc();
    chk3("sn3_local", VL);
    chk("sn3_data", {16'd0, l3.data}, 32'h0C10);
    in3 = '0;
    cyc();
    chk3("sn3_end", VN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
